// File: rtl/fifo_read_port.sv
// fifo_read_port
// Read-side consumer for the FIFO. Pops words while the FIFO is non-empty
// and there is room, and hands them downstream on a valid/ready stream
// through a two-entry (main + skid) buffer. That buffer sustains one word
// per cycle under backpressure without ever popping an empty FIFO.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   en         drain enable; low blocks new pops, buffered words still drain
//   empty      FIFO empty flag from FIFO control
//   r_data     register-file data at the current FIFO read address
//   read       pop request to FIFO control (combinational)
//   out_valid  output word valid
//   out_ready  downstream accepts the word
//   out_data   output word (main register)
//   rd_count   words popped since reset, wraps modulo 2**cnt_width
//
// state | meaning
// ------+--------------------------------------------
// S0    | buffer empty
// S1    | main register holds a word
// S2    | main and skid registers both hold words

module fifo_read_port #(
   parameter int width     = 8,
   parameter int cnt_width = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 empty,
   input  logic [width-1:0]     r_data,
   output logic                 read,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [width-1:0]     out_data,
   output logic [cnt_width-1:0] rd_count
);

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [width-1:0] main_q;
   logic [width-1:0] skid_q;
   logic             xfer;
   logic             load_main_rdata;
   logic             load_main_skid;
   logic             load_skid;

   // reset is folded into read so the pop request drops the moment reset
   // asserts, not at the next edge.
   assign read      = reset & en & ~empty & (state != S2);
   assign out_valid = (state != S0);
   assign xfer      = out_valid & out_ready;
   assign out_data  = main_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S0;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      load_main_rdata = 1'b0;
      load_main_skid  = 1'b0;
      load_skid       = 1'b0;
      case (state)
         S0: begin
            if (read) begin
               load_main_rdata = 1'b1;
               state_nxt       = S1;
            end
         end
         S1: begin
            if (xfer && read) begin
               load_main_rdata = 1'b1;
            end else if (xfer) begin
               state_nxt = S0;
            end else if (read) begin
               load_skid = 1'b1;
               state_nxt = S2;
            end
         end
         S2: begin
            if (xfer) begin
               load_main_skid = 1'b1;
               state_nxt      = S1;
            end
         end
         default: begin
            state_nxt = S0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_rdata) begin
            main_q <= r_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= r_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_count <= '0;
      end else if (read) begin
         rd_count <= rd_count + 1'b1;
      end
   end

endmodule
